// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register address width, forward-select encoding and
// a helper that pulls one stage's destination out of the flat stage bus.
package pipe_pkg;

    localparam int RA_W     = 5;
    localparam int RA_MAX   = 8;
    localparam int STG_MAX  = 16;
    localparam int FLAT_MAX = RA_MAX * STG_MAX;

    localparam int FWD_RF   = 0;
    localparam int FWD_STG1 = 1;

    // Stage k (1-based) occupies bits [k*ra_w-1 -: ra_w] of the flat bus.
    function automatic logic [RA_MAX-1:0] stage_rd(input logic [FLAT_MAX-1:0] flat,
                                                   input int unsigned         k,
                                                   input int unsigned         ra_w);
        logic [RA_MAX-1:0] mask;
        mask = RA_MAX'((1 << ra_w) - 1);
        return RA_MAX'(flat >> ((k - 1) * ra_w)) & mask;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Core-side bundle of the forwarding/hazard unit: operand addresses, stage
// destinations, multi-cycle issue/done events and the resulting controls.
interface fwd_hazard_unit_if #(
    parameter int NSTAGES = 3,
    parameter int RA_W    = pipe_pkg::RA_W,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(NSTAGES + 1);

    logic [RA_W-1:0]         ex_rs1;
    logic [RA_W-1:0]         ex_rs2;
    logic [NSTAGES*RA_W-1:0] stg_rd;
    logic [NSTAGES-1:0]      stg_we;
    logic [RA_W-1:0]         id_rs1;
    logic [RA_W-1:0]         id_rs2;
    logic                    id_use_rs1;
    logic                    id_use_rs2;
    logic [RA_W-1:0]         id_rd;
    logic                    id_we;
    logic                    ex_is_load;
    logic [RA_W-1:0]         ex_rd;
    logic                    ex_we;
    logic                    mc_issue;
    logic [RA_W-1:0]         mc_rd;
    logic                    mc_done;
    logic [RA_W-1:0]         mc_done_rd;
    logic                    cnt_clr;
    logic [SEL_W-1:0]        forward_a;
    logic [SEL_W-1:0]        forward_b;
    logic                    stall;
    logic                    mc_busy;
    logic                    sb_err;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output ex_rs1, ex_rs2, stg_rd, stg_we, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_we, ex_is_load, ex_rd, ex_we, mc_issue, mc_rd, mc_done,
               mc_done_rd, cnt_clr,
        input  forward_a, forward_b, stall, mc_busy, sb_err, stall_cnt
    );

    modport slave (
        input  ex_rs1, ex_rs2, stg_rd, stg_we, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_we, ex_is_load, ex_rd, ex_we, mc_issue, mc_rd, mc_done,
               mc_done_rd, cnt_clr,
        output forward_a, forward_b, stall, mc_busy, sb_err, stall_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard for multi-cycle ops, with a sticky protocol
// error flag for unmatched done events or double issue to one register.
module reg_scoreboard #(
    parameter int RA_W = pipe_pkg::RA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_issue,
    input  logic [RA_W-1:0]      i_issue_rd,
    input  logic                 i_done,
    input  logic [RA_W-1:0]      i_done_rd,
    output logic [2**RA_W-1:0]   o_pend,
    output logic                 o_busy,
    output logic                 o_err
);
    localparam int NREG = 2**RA_W;

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;
    logic            r_err;
    logic            w_same_rd;
    logic            w_err_set;

    // An issue and a done on the same register in one cycle is a clean hand-over.
    assign w_same_rd = i_issue && i_done && (i_issue_rd == i_done_rd);

    always_comb begin
        w_pend_nxt = r_pend;
        if (i_done) w_pend_nxt[i_done_rd] = 1'b0;
        if (i_issue) w_pend_nxt[i_issue_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    assign w_err_set = (i_done  && !r_pend[i_done_rd]  && !w_same_rd) ||
                       (i_issue &&  r_pend[i_issue_rd] && !w_same_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign o_pend = r_pend;
    assign o_busy = |r_pend;
    assign o_err  = r_err;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand bypass selection (nearest stage first), load-use and multi-cycle
// scoreboard stall generation, and a saturating stall-cycle counter.
module fwd_hazard_unit #(
    parameter int NSTAGES = 3,
    parameter int RA_W    = pipe_pkg::RA_W,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave bus
);
    import pipe_pkg::*;

    localparam int SEL_W = $clog2(NSTAGES + 1);
    localparam int NREG  = 2**RA_W;

    logic [FLAT_MAX-1:0] w_flat;
    logic [RA_W-1:0]     w_stg_rd [NSTAGES];
    logic [SEL_W-1:0]    w_fwd_a;
    logic [SEL_W-1:0]    w_fwd_b;
    logic                w_load_use;
    logic                w_sb_stall;
    logic                w_stall;
    logic [NREG-1:0]     w_pend;
    logic                w_busy;
    logic                w_err;
    logic [CNT_W-1:0]    r_stall_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_flat = FLAT_MAX'(bus.stg_rd);

    always_comb begin
        for (int unsigned k = 0; k < NSTAGES; k++)
            w_stg_rd[k] = RA_W'(stage_rd(w_flat, k + 1, RA_W));
    end

    // Walk from the farthest stage down so the nearest matching stage wins.
    always_comb begin
        w_fwd_a = SEL_W'(FWD_RF);
        w_fwd_b = SEL_W'(FWD_RF);
        for (int k = NSTAGES; k >= 1; k--) begin
            if (bus.stg_we[k-1] && (w_stg_rd[k-1] != '0)) begin
                if (w_stg_rd[k-1] == bus.ex_rs1) w_fwd_a = SEL_W'(FWD_STG1 + k - 1);
                if (w_stg_rd[k-1] == bus.ex_rs2) w_fwd_b = SEL_W'(FWD_STG1 + k - 1);
            end
        end
    end

    assign w_load_use = bus.ex_is_load && bus.ex_we && (bus.ex_rd != '0) &&
                        ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Multi-cycle results are never bypassed, so any pending source or destination blocks ID.
    assign w_sb_stall = (bus.id_use_rs1 && w_pend[bus.id_rs1]) ||
                        (bus.id_use_rs2 && w_pend[bus.id_rs2]) ||
                        (bus.id_we      && w_pend[bus.id_rd]);

    assign w_stall = w_load_use || w_sb_stall;

    always_ff @(posedge clk) begin
        if (!rst_n)           r_stall_cnt <= '0;
        else if (bus.cnt_clr) r_stall_cnt <= '0;
        else if (w_stall)     r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    reg_scoreboard #(
        .RA_W (RA_W)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_issue    (bus.mc_issue),
        .i_issue_rd (bus.mc_rd),
        .i_done     (bus.mc_done),
        .i_done_rd  (bus.mc_done_rd),
        .o_pend     (w_pend),
        .o_busy     (w_busy),
        .o_err      (w_err)
    );

    assign bus.forward_a = w_fwd_a;
    assign bus.forward_b = w_fwd_b;
    assign bus.stall     = w_stall;
    assign bus.mc_busy   = w_busy;
    assign bus.sb_err    = w_err;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random stimulus for fwd_hazard_unit, checked against a
// register-array reference model of forwarding, hazards and the scoreboard.
module tb_fwd_hazard_unit;
    localparam int NS   = 3;
    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int NREG = 32;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NSTAGES(NS), .RA_W(RW), .CNT_W(CW)) bus();

    fwd_hazard_unit #(.NSTAGES(NS), .RA_W(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    bit m_pend [NREG];
    bit m_err;
    int m_cnt;

    function automatic int exp_fwd(input logic [RW-1:0] rs);
        logic [RW-1:0] d;
        for (int k = 1; k <= NS; k++) begin
            d = bus.stg_rd[k*RW-1 -: RW];
            if (bus.stg_we[k-1] && rs != 0 && d == rs) return k;
        end
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit lu, sb;
        lu = bus.ex_is_load && bus.ex_we && bus.ex_rd != 0 &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        sb = (bus.id_use_rs1 && m_pend[bus.id_rs1]) ||
             (bus.id_use_rs2 && m_pend[bus.id_rs2]) ||
             (bus.id_we      && m_pend[bus.id_rd]);
        return lu || sb;
    endfunction

    function automatic int busy_of();
        for (int r = 0; r < NREG; r++) if (m_pend[r]) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fwd_a"}, 32'(bus.forward_a), exp_fwd(bus.ex_rs1));
        chk({tag, ".fwd_b"}, 32'(bus.forward_b), exp_fwd(bus.ex_rs2));
        chk({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall()));
        chk({tag, ".busy"},  32'(bus.mc_busy), busy_of());
        chk({tag, ".err"},   32'(bus.sb_err), 32'(m_err));
        chk({tag, ".cnt"},   32'(bus.stall_cnt), m_cnt);
    endtask

    task automatic idle();
        bus.ex_rs1 = '0;  bus.ex_rs2 = '0;  bus.stg_rd = '0;  bus.stg_we = '0;
        bus.id_rs1 = '0;  bus.id_rs2 = '0;  bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.id_rd = '0;   bus.id_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = '0;
        bus.ex_we = 1'b0; bus.mc_issue = 1'b0; bus.mc_rd = '0; bus.mc_done = 1'b0;
        bus.mc_done_rd = '0; bus.cnt_clr = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic tick();
        bit s, same;
        s = exp_stall();
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            same = bus.mc_issue && bus.mc_done && bus.mc_rd == bus.mc_done_rd;
            if (bus.mc_done && !m_pend[bus.mc_done_rd] && !same) m_err = 1'b1;
            if (bus.mc_issue && m_pend[bus.mc_rd] && !same) m_err = 1'b1;
            if (bus.mc_done) m_pend[bus.mc_done_rd] = 1'b0;
            if (bus.mc_issue && bus.mc_rd != 0) m_pend[bus.mc_rd] = 1'b1;
            if (bus.cnt_clr) m_cnt = 0;
            else if (s && m_cnt < CMAX) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        m_err = 1'b0;
        m_cnt = 0;
        rst_n = 1'b0;
        settle();
        tick();
        check_all("reset");
        chk("reset_busy", 32'(bus.mc_busy), 0);
        chk("reset_cnt", 32'(bus.stall_cnt), 0);
        rst_n = 1'b1;

        // Forwarding priority
        bus.ex_rs1 = RW'(5);
        bus.stg_rd = {RW'(5), RW'(5), RW'(5)};
        bus.stg_we = 3'b111;
        settle();
        chk("fwd_all_we", 32'(bus.forward_a), 1);
        check_all("fwd1");
        bus.stg_we = 3'b110;
        settle();
        chk("fwd_drop_s1", 32'(bus.forward_a), 2);
        bus.ex_rs2 = RW'(5);
        bus.stg_we = 3'b100;
        settle();
        chk("fwd_b_s3", 32'(bus.forward_b), 3);
        bus.ex_rs1 = '0;
        bus.stg_rd = '0;
        bus.stg_we = 3'b111;
        settle();
        chk("fwd_rs0", 32'(bus.forward_a), 0);
        check_all("fwd2");

        // Load-use
        idle();
        bus.ex_is_load = 1'b1; bus.ex_rd = RW'(7); bus.ex_we = 1'b1;
        bus.id_rs2 = RW'(7);   bus.id_use_rs2 = 1'b1;
        settle();
        chk("lu_stall", 32'(bus.stall), 1);
        tick();
        bus.ex_is_load = 1'b0;
        settle();
        chk("lu_bubble", 32'(bus.stall), 0);
        chk("lu_cnt", 32'(bus.stall_cnt), 1);
        check_all("lu");
        tick();
        bus.ex_is_load = 1'b1; bus.id_use_rs2 = 1'b0;
        settle();
        chk("lu_nouse", 32'(bus.stall), 0);
        tick();

        // Multi-cycle RAW on r9
        idle();
        bus.mc_issue = 1'b1; bus.mc_rd = RW'(9);
        settle();
        tick();
        idle();
        bus.id_rs1 = RW'(9); bus.id_use_rs1 = 1'b1;
        settle();
        chk("raw_busy_t1", 32'(bus.mc_busy), 1);
        chk("raw_stall_t1", 32'(bus.stall), 1);
        tick();
        chk("raw_stall_t2", 32'(bus.stall), 1);
        tick();
        bus.mc_done = 1'b1; bus.mc_done_rd = RW'(9);
        settle();
        chk("raw_stall_t3", 32'(bus.stall), 1);
        check_all("raw_t3");
        tick();
        bus.mc_done = 1'b0;
        settle();
        chk("raw_stall_t4", 32'(bus.stall), 0);
        chk("raw_busy_t4", 32'(bus.mc_busy), 0);

        // WAW on r12 and issue/done hand-over
        idle();
        bus.mc_issue = 1'b1; bus.mc_rd = RW'(12);
        settle();
        tick();
        idle();
        bus.id_rd = RW'(12); bus.id_we = 1'b1;
        settle();
        chk("waw_stall", 32'(bus.stall), 1);
        bus.mc_issue = 1'b1; bus.mc_rd = RW'(12);
        bus.mc_done = 1'b1;  bus.mc_done_rd = RW'(12);
        settle();
        tick();
        bus.mc_issue = 1'b0; bus.mc_done = 1'b0;
        settle();
        chk("handover_stall", 32'(bus.stall), 1);
        chk("handover_err", 32'(bus.sb_err), 0);
        check_all("handover");
        idle();
        bus.mc_done = 1'b1; bus.mc_done_rd = RW'(12);
        settle();
        tick();
        idle();
        settle();
        chk("waw_clear_busy", 32'(bus.mc_busy), 0);

        // Spurious done (r4) alongside a good issue (r6), then reset
        bus.mc_done = 1'b1;  bus.mc_done_rd = RW'(4);
        bus.mc_issue = 1'b1; bus.mc_rd = RW'(6);
        settle();
        tick();
        idle();
        settle();
        chk("err_set", 32'(bus.sb_err), 1);
        chk("err_busy", 32'(bus.mc_busy), 1);
        tick();
        chk("err_sticky", 32'(bus.sb_err), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst_err", 32'(bus.sb_err), 0);
        chk("rst_busy", 32'(bus.mc_busy), 0);
        chk("rst_cnt", 32'(bus.stall_cnt), 0);
        check_all("rst");

        // Counter saturation and clear priority
        bus.mc_issue = 1'b1; bus.mc_rd = RW'(3);
        settle();
        tick();
        idle();
        bus.id_rs1 = RW'(3); bus.id_use_rs1 = 1'b1;
        settle();
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", 32'(bus.stall_cnt), CMAX);
        tick();
        chk("sat_hold", 32'(bus.stall_cnt), CMAX);
        bus.cnt_clr = 1'b1;
        settle();
        chk("clr_stall", 32'(bus.stall), 1);
        tick();
        bus.cnt_clr = 1'b0;
        settle();
        chk("clr_cnt", 32'(bus.stall_cnt), 0);
        check_all("clr");
        idle();
        bus.mc_done = 1'b1; bus.mc_done_rd = RW'(3);
        settle();
        tick();
        idle();

        // Random traffic over a small register window
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            bus.ex_rs1 = RW'($urandom_range(0, 7));
            bus.ex_rs2 = RW'($urandom_range(0, 7));
            for (int k = 0; k < NS; k++) bus.stg_rd[k*RW +: RW] = RW'($urandom_range(0, 7));
            bus.stg_we     = NS'($urandom);
            bus.id_rs1     = RW'($urandom_range(0, 7));
            bus.id_rs2     = RW'($urandom_range(0, 7));
            bus.id_use_rs1 = 1'($urandom);
            bus.id_use_rs2 = 1'($urandom);
            bus.id_rd      = RW'($urandom_range(0, 7));
            bus.id_we      = 1'($urandom);
            bus.ex_is_load = 1'($urandom);
            bus.ex_rd      = RW'($urandom_range(0, 7));
            bus.ex_we      = 1'($urandom);
            bus.mc_issue   = ($urandom_range(0, 3) == 0);
            bus.mc_rd      = RW'($urandom_range(0, 7));
            bus.mc_done    = ($urandom_range(0, 3) == 0);
            bus.mc_done_rd = RW'($urandom_range(0, 7));
            bus.cnt_clr    = ($urandom_range(0, 15) == 0);
            settle();
            check_all("rand");
            tick();
        end
        rst_n = 1'b1;
        idle();
        settle();
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
